// File: rtl/cgra_pkt_pkg.sv
// Shared definitions for the CGRA result-path packetiser.
// Holds the CGRA packet field widths, the AXI-Stream slot geometry, the
// packet/beat container types and the transmit FSM state encoding.
package cgra_pkt_pkg;

  localparam int CGRA_DATA_W = 67;
  localparam int CGRA_CTRL_W = 107;
  localparam int MCGR_PAY_W  = 190;
  localparam int PKT_HDR_W   = 27;
  localparam int CGRA_PKT_W  = 217;
  localparam int AXIS_W      = 64;
  localparam int SLOT_BYTES  = 32;

  typedef logic [CGRA_PKT_W-1:0] cgra_pkt_t;
  typedef logic [AXIS_W-1:0]     axis_beat_t;

  // IDLE: waiting for a packet. SEND: streaming the held slot.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cgra_pkt_to_axis.sv
// cgra_pkt_to_axis
// Takes one CGRA packet over a val/rdy port and emits it as a fixed
// BEATS-beat AXI-Stream burst. The packet is zero-extended into a
// BEATS*AXIS_W slot; beat k carries slot bits [k*AXIS_W +: AXIS_W].
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   s_pkt_msg/s_pkt_val/s_pkt_rdy   CGRA packet input (val/rdy)
//   m_axis_tdata/tkeep/tvalid/tlast AXI-Stream master
//   m_axis_tready                   AXI-Stream sink ready
//   busy                            a packet is being streamed
//   pkt_cnt                         packets fully sent (wraps)
module cgra_pkt_to_axis #(
  parameter int PKT_W  = cgra_pkt_pkg::CGRA_PKT_W,
  parameter int AXIS_W = cgra_pkt_pkg::AXIS_W,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PKT_W-1:0]    s_pkt_msg,
  input  logic                s_pkt_val,
  output logic                s_pkt_rdy,
  output logic [AXIS_W-1:0]   m_axis_tdata,
  output logic [AXIS_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_cnt
);
  import cgra_pkt_pkg::*;

  localparam int SLOT_W = BEATS * AXIS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (SLOT_W < PKT_W) begin : g_bad_slot
    $error("cgra_pkt_to_axis: BEATS*AXIS_W is smaller than PKT_W");
  end
  if ((AXIS_W % 8) != 0) begin : g_bad_axis_w
    $error("cgra_pkt_to_axis: AXIS_W must be a multiple of 8");
  end

  tx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic [SLOT_W-1:0] hold_q,  hold_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              in_send;
  logic              is_last;
  logic              accept;
  logic              beat_hs;
  logic [SLOT_W-1:0] pkt_ext;

  always_comb begin
    in_send = (state_q == ST_SEND);
    is_last = (beat_q == LAST_BEAT);

    m_axis_tvalid = in_send;
    m_axis_tlast  = in_send && is_last;
    m_axis_tkeep  = '1;
    m_axis_tdata  = in_send ? hold_q[int'(beat_q)*AXIS_W +: AXIS_W] : '0;
    busy          = in_send;
    pkt_cnt       = cnt_q;

    // In SEND a new packet can only enter on the cycle the last beat
    // leaves, which keeps back-to-back bursts gap-free. The rstn term
    // keeps the upstream from seeing ready while the block is in reset.
    s_pkt_rdy = rstn && (in_send ? (m_axis_tready && is_last) : 1'b1);

    accept  = s_pkt_val && s_pkt_rdy;
    beat_hs = in_send && m_axis_tready;

    pkt_ext              = '0;
    pkt_ext[PKT_W-1:0]   = s_pkt_msg;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hold_d  = pkt_ext;
          beat_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_hs) begin
          if (is_last) begin
            cnt_d  = cnt_q + CNT_W'(1);
            beat_d = '0;
            if (accept) begin
              hold_d = pkt_ext;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
